ivl_uvm_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one resource between `NUM_REQ` requesters. It produces a registered one-hot grant vector (`gnt`), which the OVL benches check with `$countones(gnt) <= 1` and an `ovl_always` on `gnt_valid == |gnt`. A grant lasts until the requester drops its request or the hold budget expires. The block exposes its 2-bit FSM state so that an `ovl_transition` checker can monitor legal state changes.

---
 rtl/ivl_uvm_rr_arbiter.sv | 117 +++++++++++
 tb/tb_ivl_uvm_rr_arbiter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/ivl_uvm_rr_arbiter.sv
// Round-robin arbiter with a registered one-hot grant, a per-tenure hold budget
// and an exposed 2-bit FSM state for external transition checkers.
module ivl_uvm_rr_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4,
    parameter int ID_W     = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic               gnt_valid,
    output logic [ID_W-1:0]    gnt_id,
    output logic [1:0]         state,
    output logic               timeout
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        BUSY    = 2'b01,
        RELEASE = 2'b10
    } state_e;

    state_e             state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [ID_W-1:0]    gnt_id_q, gnt_id_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic               timeout_q, timeout_d;

    logic [NUM_REQ-1:0] mask_hi;
    logic [NUM_REQ-1:0] req_hi;
    logic [NUM_REQ-1:0] pick;
    logic [ID_W-1:0]    winner;
    logic [ID_W-1:0]    ptr_after;
    logic               owner_req;
    logic               budget_hit;

    // Requests at or above ptr win first; if none, the search wraps to index 0.
    always_comb begin
        mask_hi = ~((NUM_REQ'(1) << ptr_q) - NUM_REQ'(1));
        req_hi  = req & mask_hi;
        pick    = (|req_hi) ? req_hi : req;
        winner  = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (pick[i]) winner = ID_W'(i);
        end
    end

    assign owner_req  = |(req & gnt_q);
    assign budget_hit = (MAX_HOLD != 0) && (hold_cnt_q == CNT_W'(MAX_HOLD));
    assign ptr_after  = (gnt_id_q == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id_q + ID_W'(1);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d    = state_q;
        gnt_d      = gnt_q;
        gnt_id_d   = gnt_id_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        timeout_d  = 1'b0;
        case (state_q)
            IDLE, RELEASE: begin
                gnt_d   = '0;
                state_d = IDLE;
                if (|req) begin
                    state_d    = BUSY;
                    gnt_d      = NUM_REQ'(1) << winner;
                    gnt_id_d   = winner;
                    hold_cnt_d = CNT_W'(1);
                end
            end
            BUSY: begin
                if (!owner_req || budget_hit) begin
                    // The pointer moves past the owner now, so the bubble already arbitrates with it.
                    state_d   = RELEASE;
                    gnt_d     = '0;
                    timeout_d = owner_req;
                    ptr_d     = ptr_after;
                end else if (hold_cnt_q != '1) begin
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            gnt_id_q   <= '0;
            ptr_q      <= '0;
            hold_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            gnt_id_q   <= gnt_id_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_valid = |gnt_q;
    assign gnt_id    = gnt_id_q;
    assign state     = state_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_ivl_uvm_rr_arbiter.sv
// Self-checking bench: two arbiters (hold budget 8 and unlimited) driven by directed
// and random requests, compared every cycle against a behavioural reference model.
module tb_ivl_uvm_rr_arbiter;

    localparam int N    = 4;
    localparam int ID_W = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_a = '0;
    logic [N-1:0]    req_b = '0;
    logic [N-1:0]    gnt_a, gnt_b;
    logic            gv_a, gv_b;
    logic [ID_W-1:0] id_a, id_b;
    logic [1:0]      st_a, st_b;
    logic            to_a, to_b;

    always #5 clk = ~clk;

    ivl_uvm_rr_arbiter #(.NUM_REQ(N), .MAX_HOLD(8), .CNT_W(4)) dut_a (
        .clk(clk), .rst(rst), .req(req_a), .gnt(gnt_a), .gnt_valid(gv_a),
        .gnt_id(id_a), .state(st_a), .timeout(to_a)
    );

    ivl_uvm_rr_arbiter #(.NUM_REQ(N), .MAX_HOLD(0), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .req(req_b), .gnt(gnt_b), .gnt_valid(gv_b),
        .gnt_id(id_b), .state(st_b), .timeout(to_b)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model: who owns the resource, for how long, whether a bubble is
    // in progress, and which requester has first priority next.
    int m_owner [2] = '{-1, -1};
    int m_held  [2] = '{0, 0};
    int m_first [2] = '{0, 0};
    int m_id    [2] = '{0, 0};
    bit m_bubble[2] = '{1'b0, 1'b0};
    bit m_to    [2] = '{1'b0, 1'b0};
    int m_max   [2] = '{8, 0};

    function automatic bit bit_at(input logic [N-1:0] v, input int i);
        logic [N-1:0] t;
        t = v >> i;
        return t[0];
    endfunction

    task automatic model_update(input int k, input logic [N-1:0] r, input logic rs);
        m_to[k] = 1'b0;
        if (rs) begin
            m_owner[k] = -1; m_held[k] = 0; m_first[k] = 0; m_id[k] = 0; m_bubble[k] = 1'b0;
        end else if (m_owner[k] >= 0) begin
            if (!bit_at(r, m_owner[k]) || (m_max[k] != 0 && m_held[k] == m_max[k])) begin
                m_to[k]     = bit_at(r, m_owner[k]);
                m_first[k]  = (m_owner[k] + 1) % N;
                m_owner[k]  = -1;
                m_bubble[k] = 1'b1;
            end else begin
                m_held[k]++;
            end
        end else begin
            m_bubble[k] = 1'b0;
            for (int j = 0; j < N; j++) begin
                int c;
                c = (m_first[k] + j) % N;
                if (m_owner[k] < 0 && bit_at(r, c)) begin
                    m_owner[k] = c; m_held[k] = 1; m_id[k] = c;
                end
            end
        end
    endtask

    task automatic check_dut(input int k);
        logic [N-1:0]    g, eg;
        logic            v, t;
        logic [ID_W-1:0] id;
        logic [1:0]      s, es;
        string           p;
        if (k == 0) begin g = gnt_a; v = gv_a; id = id_a; s = st_a; t = to_a; p = "A"; end
        else        begin g = gnt_b; v = gv_b; id = id_b; s = st_b; t = to_b; p = "B"; end
        eg = (m_owner[k] >= 0) ? (N'(1) << m_owner[k]) : '0;
        es = (m_owner[k] >= 0) ? 2'b01 : (m_bubble[k] ? 2'b10 : 2'b00);
        check({p, ".gnt"},       32'(g),  32'(eg));
        check({p, ".gnt_valid"}, 32'(v),  32'(m_owner[k] >= 0));
        check({p, ".gnt_id"},    32'(id), 32'(m_id[k]));
        check({p, ".state"},     32'(s),  32'(es));
        check({p, ".timeout"},   32'(t),  32'(m_to[k]));
    endtask

    task automatic step(input logic [N-1:0] ra, input logic [N-1:0] rb, input logic rs);
        req_a = ra;
        req_b = rb;
        rst   = rs;
        @(posedge clk);
        model_update(0, ra, rs);
        model_update(1, rb, rs);
        #1;
        check_dut(0);
        check_dut(1);
    endtask

    initial begin
        int order[$];
        bit prev_gv;
        int run_len, max_len, n_to_a, n_to_b, bad_b;
        logic [N-1:0] ra, rb;

        // Reset held with all requests active, then saturation on A and unlimited hold on B.
        for (int i = 0; i < 3; i++) step(4'b1111, 4'b0011, 1'b1);
        step(4'b1111, 4'b0011, 1'b0);
        check("rst.first_gnt", 32'(gnt_a), 32'h1);
        prev_gv = gv_a; run_len = gv_a ? 1 : 0; max_len = run_len;
        n_to_a = 0; n_to_b = 0; bad_b = (gnt_b != 4'b0001) ? 1 : 0;
        order.delete();
        if (gv_a) order.push_back(int'(id_a));
        for (int i = 0; i < 43; i++) begin
            step(4'b1111, 4'b0011, 1'b0);
            if (gv_a && !prev_gv) order.push_back(int'(id_a));
            run_len = gv_a ? run_len + 1 : 0;
            if (run_len > max_len) max_len = run_len;
            if (to_a) n_to_a++;
            if (to_b) n_to_b++;
            if (gnt_b != 4'b0001) bad_b++;
            prev_gv = gv_a;
        end
        check("sat.n_grants", 32'(order.size()), 32'd5);
        for (int i = 0; i < 5; i++) check("sat.order", 32'(i < order.size() ? order[i] : -1), 32'(i % 4));
        check("sat.max_len", 32'(max_len), 32'd8);
        check("sat.timeouts", 32'(n_to_a), 32'd4);
        check("unl.gnt_stuck", 32'(bad_b), 32'd0);
        check("unl.timeouts", 32'(n_to_b), 32'd0);
        step(4'b0000, 4'b0010, 1'b0);
        check("unl.bubble_state", 32'(st_b), 32'h2);
        check("unl.bubble_gnt", 32'(gnt_b), 32'h0);
        step(4'b0000, 4'b0010, 1'b0);
        check("unl.next_gnt", 32'(gnt_b), 32'h2);

        // Single request: grant, hold, drop, bubble, idle.
        step(4'b0000, 4'b0000, 1'b1);
        step(4'b0100, 4'b0000, 1'b0);
        check("single.gnt", 32'(gnt_a), 32'h4);
        check("single.id", 32'(id_a), 32'd2);
        for (int i = 0; i < 3; i++) step(4'b0100, 4'b0000, 1'b0);
        step(4'b0000, 4'b0000, 1'b0);
        check("single.drop_gnt", 32'(gnt_a), 32'h0);
        check("single.drop_state", 32'(st_a), 32'h2);
        step(4'b0000, 4'b0000, 1'b0);
        check("single.idle_state", 32'(st_a), 32'h0);

        // Mid-grant reset clears the pointer (it would otherwise favour requester 3).
        step(4'b0100, 4'b0000, 1'b0);
        check("midrst.pre_gnt", 32'(gnt_a), 32'h4);
        step(4'b1111, 4'b0000, 1'b1);
        check("midrst.gnt", 32'(gnt_a), 32'h0);
        step(4'b1111, 4'b0000, 1'b0);
        check("midrst.after_gnt", 32'(gnt_a), 32'h1);

        // Sparse requests: each requester drops after two granted cycles, then reasserts.
        step(4'b0000, 4'b0000, 1'b1);
        order.delete();
        prev_gv = 1'b0; n_to_a = 0;
        for (int i = 0; i < 14; i++) begin
            ra = 4'b1010;
            if (m_owner[0] == 1 && m_held[0] >= 2) ra[1] = 1'b0;
            if (m_owner[0] == 3 && m_held[0] >= 2) ra[3] = 1'b0;
            step(ra, 4'b0000, 1'b0);
            if (gv_a && !prev_gv) order.push_back(int'(id_a));
            if (to_a) n_to_a++;
            prev_gv = gv_a;
        end
        check("sparse.n_grants", 32'(order.size() >= 4), 32'd1);
        for (int i = 0; i < 4; i++) check("sparse.order", 32'(i < order.size() ? order[i] : -1), (i % 2 == 0) ? 32'd1 : 32'd3);
        check("sparse.timeouts", 32'(n_to_a), 32'd0);

        // Random traffic with occasional resets, checked cycle by cycle against the model.
        ra = '0; rb = '0;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 3) == 0) ra = N'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) rb = N'($urandom_range(0, 15));
            step(ra, rb, ($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
